// File: rtl/card_dealer.sv
// card_dealer: deals random cards from a 10-card black/white deck into two hands
// using an 8-bit Fibonacci LFSR, one candidate card per cycle.
module card_dealer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       deal_start,
  input  logic [2:0] deal_num,
  input  logic       player,
  input  logic       clear,
  input  logic       seed_load,
  input  logic [7:0] seed,
  output logic [9:0] p_card_a,
  output logic [9:0] p_card_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] remaining
);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [9:0] hand_a_q, hand_a_d, hand_b_q, hand_b_d;
  logic [2:0] count_q, count_d;
  logic       player_q, player_d;
  logic       busy_q, busy_d, done_q, done_d;

  logic [9:0]  used;
  logic [15:0] used_ext;
  logic [3:0]  idx, ones;
  logic [9:0]  pick;
  logic [2:0]  want, grant;
  logic        accept, fb;

  assign used     = hand_a_q | hand_b_q;
  assign used_ext = {6'b0, used};
  assign idx      = lfsr_q[3:0];
  assign pick     = 10'b1 << idx;
  assign fb       = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign accept   = state_q == DRAW && count_q != 3'd0 && idx < 4'd10 && !used_ext[idx];

  always_comb begin
    ones = '0;
    for (int i = 0; i < 10; i++) ones = ones + {3'b0, used[i]};
  end

  assign remaining = 4'd10 - ones;
  assign want      = deal_num > 3'd5 ? 3'd5 : deal_num;
  // want never exceeds 5, so a shortfall always fits in three bits
  assign grant     = remaining >= {1'b0, want} ? want : remaining[2:0];

  always_comb begin
    state_d  = state_q;
    hand_a_d = hand_a_q;
    hand_b_d = hand_b_q;
    count_d  = count_q;
    player_d = player_q;
    lfsr_d   = seed_load ? (seed == 8'h00 ? 8'hA5 : seed) : {lfsr_q[6:0], fb};
    if (clear) begin
      state_d  = IDLE;
      hand_a_d = '0;
      hand_b_d = '0;
      count_d  = '0;
    end else if (state_q == IDLE) begin
      if (deal_start) begin
        state_d  = DRAW;
        player_d = player;
        count_d  = grant;
      end
    end else if (state_q == DRAW) begin
      if (count_q == 3'd0) begin
        state_d = DONE;
      end else if (accept) begin
        hand_a_d = player_q ? hand_a_q : hand_a_q | pick;
        hand_b_d = player_q ? hand_b_q | pick : hand_b_q;
        count_d  = count_q - 3'd1;
      end
    end else begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= 8'hA5;
      hand_a_q <= '0;
      hand_b_q <= '0;
      count_q  <= '0;
      player_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      hand_a_q <= hand_a_d;
      hand_b_q <= hand_b_d;
      count_q  <= count_d;
      player_q <= player_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign p_card_a = hand_a_q;
  assign p_card_b = hand_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed checks of dealing, clamping, aborts and ignored
// restarts on card_dealer.
module tb_card_dealer;
  logic       clk = 1'b0;
  logic       rst_n, deal_start, player, clear, seed_load;
  logic [2:0] deal_num;
  logic [7:0] seed;
  logic [9:0] p_card_a, p_card_b;
  logic       busy, done;
  logic [3:0] remaining;

  int passed = 0;
  int total  = 0;
  int dones, busyc;
  logic [9:0] a1, sa, sb;

  card_dealer dut (
    .clk(clk), .rst_n(rst_n), .deal_start(deal_start), .deal_num(deal_num),
    .player(player), .clear(clear), .seed_load(seed_load), .seed(seed),
    .p_card_a(p_card_a), .p_card_b(p_card_b), .busy(busy), .done(done),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic load_seed(input logic [7:0] s);
    @(negedge clk);
    seed_load = 1'b1;
    seed = s;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // starts a deal and watches it to completion plus a short tail
  task automatic run_deal(input logic [2:0] num, input logic pl, input logic repulse,
                          output int nd, output int nb);
    int n;
    nd = 0;
    nb = 0;
    @(negedge clk);
    deal_start = 1'b1;
    deal_num = num;
    player = pl;
    @(negedge clk);
    deal_start = 1'b0;
    deal_num = 3'd5;
    for (n = 0; n < 400; n++) begin
      if (busy) nb++;
      if (done) nd++;
      if (!busy) break;
      deal_start = (repulse && n == 1);
      @(negedge clk);
    end
    deal_start = 1'b0;
    if (n == 400) chk("deal_timeout", {31'b0, busy}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
    end
  endtask

  task automatic count_quiet(output int nd);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
  endtask

  initial begin
    rst_n = 1'b0; deal_start = 1'b0; deal_num = 3'd0; player = 1'b0;
    clear = 1'b0; seed_load = 1'b0; seed = 8'h00;
    #3;
    chk("rst_remaining", {28'b0, remaining}, 32'd10);
    chk("rst_hands", {12'b0, p_card_a, p_card_b}, 32'd0);
    chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hands", {12'b0, p_card_a, p_card_b}, 32'd0);
    chk("idle_remaining", {28'b0, remaining}, 32'd10);
    chk("idle_busy_done", {30'b0, busy, done}, 32'd0);

    load_seed(8'h00);
    run_deal(3'd5, 1'b0, 1'b0, dones, busyc);
    chk("deal5_dones", dones, 1);
    chk("deal5_pop_a", $countones(p_card_a), 5);
    chk("deal5_b", {22'b0, p_card_b}, 32'd0);
    chk("deal5_remaining", {28'b0, remaining}, 32'd5);
    a1 = p_card_a;

    run_deal(3'd7, 1'b1, 1'b0, dones, busyc);
    chk("deal7_dones", dones, 1);
    chk("deal7_union", {22'b0, p_card_a | p_card_b}, 32'h3FF);
    chk("deal7_overlap", {22'b0, p_card_a & p_card_b}, 32'd0);
    chk("deal7_pop_b", $countones(p_card_b), 5);
    chk("deal7_remaining", {28'b0, remaining}, 32'd0);
    sa = p_card_a;
    sb = p_card_b;

    run_deal(3'd3, 1'b0, 1'b0, dones, busyc);
    chk("empty_dones", dones, 1);
    chk("empty_hands", {12'b0, p_card_a, p_card_b}, {12'b0, sa, sb});

    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clear_hands", {12'b0, p_card_a, p_card_b}, 32'd0);
    chk("clear_remaining", {28'b0, remaining}, 32'd10);

    run_deal(3'd0, 1'b1, 1'b0, dones, busyc);
    chk("zero_busy_cycles", busyc, 2);
    chk("zero_dones", dones, 1);
    chk("zero_hands", {12'b0, p_card_a, p_card_b}, 32'd0);

    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    load_seed(8'h00);
    run_deal(3'd5, 1'b0, 1'b0, dones, busyc);
    chk("repeat_dones", dones, 1);
    chk("repeat_same_a", {22'b0, p_card_a}, {22'b0, a1});

    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    deal_start = 1'b1; deal_num = 3'd5; player = 1'b0;
    @(negedge clk); deal_start = 1'b0;
    @(negedge clk);
    chk("abort_clr_in_draw", {31'b0, busy}, 32'd1);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("abort_clr_busy_done", {30'b0, busy, done}, 32'd0);
    chk("abort_clr_hands", {12'b0, p_card_a, p_card_b}, 32'd0);
    chk("abort_clr_remaining", {28'b0, remaining}, 32'd10);
    count_quiet(dones);
    chk("abort_clr_quiet", dones, 0);

    deal_start = 1'b1; deal_num = 3'd5; player = 1'b1;
    @(negedge clk); deal_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_busy_done", {30'b0, busy, done}, 32'd0);
    chk("abort_rst_hands", {12'b0, p_card_a, p_card_b}, 32'd0);
    chk("abort_rst_remaining", {28'b0, remaining}, 32'd10);
    @(negedge clk); rst_n = 1'b1;
    count_quiet(dones);
    chk("abort_rst_quiet", dones, 0);

    run_deal(3'd3, 1'b1, 1'b1, dones, busyc);
    chk("repulse_dones", dones, 1);
    chk("repulse_pop_b", $countones(p_card_b), 3);
    chk("repulse_a", {22'b0, p_card_a}, 32'd0);
    chk("repulse_remaining", {28'b0, remaining}, 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
